// File: rtl/ram_arb_pkg.sv
// Shared types and widths for the data-RAM access arbiter.
package ram_arb_pkg;
  localparam int RAM_ADDR_W = 7;
  localparam int RAM_DATA_W = 8;

  typedef enum logic [1:0] {ARB_IDLE, ARB_PEND, ARB_ACK} arb_state_t;
endpackage

// File: rtl/ram_access_arbiter.sv
// Shares the 128x8 data RAM between the CPU (always wins, never stalled) and a host port
// that fills CPU-free cycles via a req/ack handshake with a bounded wait.
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W  = RAM_ADDR_W,
  parameter int DATA_W  = RAM_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_window,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic              host_err,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_en,
  input  logic [DATA_W-1:0] ram_out
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t        state_q, state_d;
  logic              req_d;
  logic              armed_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic              host_we_q;
  logic [ADDR_W-1:0] host_addr_q;
  logic [DATA_W-1:0] host_wdata_q;
  logic              accept, host_sel, timed_out;

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    host_sel  = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        // armed_q blocks a req that was already high when reset released
        accept = host_req & ~req_d & armed_q;
        if (accept) state_d = ARB_PEND;
      end
      ARB_PEND: begin
        host_sel  = ~cpu_window;
        timed_out = ~host_sel & (wait_cnt == CNT_W'(TIMEOUT - 1));
        if (host_sel || timed_out) state_d = ARB_ACK;
      end
      ARB_ACK: state_d = ARB_IDLE;
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    ram_addr = host_sel ? host_addr_q  : cpu_addr;
    ram_data = host_sel ? host_wdata_q : cpu_wdata;
    ram_en   = host_sel ? host_we_q    : cpu_we;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARB_IDLE;
      req_d      <= 1'b0;
      armed_q    <= 1'b0;
      wait_cnt   <= '0;
      host_ack   <= 1'b0;
      host_err   <= 1'b0;
      host_rdata <= '0;
    end else begin
      state_q  <= state_d;
      req_d    <= host_req;
      if (!host_req) armed_q <= 1'b1;
      host_ack <= 1'b0;
      host_err <= 1'b0;
      if (accept) wait_cnt <= '0;
      if (host_sel) begin
        if (!host_we_q) host_rdata <= ram_out;
        host_ack <= 1'b1;
      end else if (timed_out) begin
        host_ack <= 1'b1;
        host_err <= 1'b1;
      end else if (state_q == ARB_PEND && wait_cnt != CNT_W'(TIMEOUT)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // Captured transaction fields carry no reset value.
  always_ff @(posedge clk) begin
    if (accept) begin
      host_we_q    <= host_we;
      host_addr_q  <= host_addr;
      host_wdata_q <= host_wdata;
    end
  end

  ap_cpu_we_in_window: assert property (@(posedge clk) disable iff (!reset_n)
    !(cpu_we && !cpu_window));
endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a behavioural 128x8 RAM attached.
module tb_ram_access_arbiter;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       cpu_window, cpu_we, host_req, host_we;
  logic [6:0] cpu_addr, host_addr, ram_addr;
  logic [7:0] cpu_wdata, host_wdata, host_rdata, ram_data, ram_out;
  logic       host_ack, host_err, ram_en;
  logic [7:0] mem [128];
  int         n_cmp = 0;
  int         n_err = 0;
  int         acks;

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_en) mem[ram_addr] <= ram_data;
  assign ram_out = mem[ram_addr];

  ram_access_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_window(cpu_window), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_err(host_err), .host_rdata(host_rdata),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_en(ram_en), .ram_out(ram_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_start(input logic we, input logic [6:0] a, input logic [7:0] d);
    host_we = we; host_addr = a; host_wdata = d; host_req = 1'b1;
  endtask

  task automatic cpu_write(input logic [6:0] a, input logic [7:0] d);
    cpu_window = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    tick();
    cpu_we = 1'b0; cpu_window = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; cpu_window = 1'b0; cpu_we = 1'b0; cpu_addr = 7'h01; cpu_wdata = 8'h00;
    host_req = 1'b0; host_we = 1'b0; host_addr = 7'h00; host_wdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", host_ack, 1'b0);
    chk("rst_err", host_err, 1'b0);
    chk("rst_rdata", host_rdata, 8'h00);
    chk("rst_ram_en", ram_en, 1'b0);
    reset_n = 1'b1;
    tick();

    // 1: unblocked write, access in N+1, ack in N+2
    host_start(1'b1, 7'h10, 8'h5A);
    tick();
    chk("t1_en", ram_en, 1'b1);
    chk("t1_addr", ram_addr, 7'h10);
    chk("t1_data", ram_data, 8'h5A);
    chk("t1_noack", host_ack, 1'b0);
    tick();
    chk("t1_ack", host_ack, 1'b1);
    chk("t1_err", host_err, 1'b0);
    chk("t1_mem", mem[7'h10], 8'h5A);
    host_req = 1'b0;
    tick();
    chk("t1_ack_low", host_ack, 1'b0);

    // 2: read blocked by cpu_window for 3 cycles
    cpu_write(7'h22, 8'hC3);
    cpu_window = 1'b1; cpu_addr = 7'h01;
    host_start(1'b0, 7'h22, 8'h00);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t2_blk_addr", ram_addr, 7'h01);
      chk("t2_blk_ack", host_ack, 1'b0);
      tick();
    end
    cpu_window = 1'b0;
    #1;
    chk("t2_addr", ram_addr, 7'h22);
    chk("t2_en", ram_en, 1'b0);
    tick();
    chk("t2_ack", host_ack, 1'b1);
    chk("t2_rdata", host_rdata, 8'hC3);
    host_req = 1'b0;
    tick();

    // 3: CPU write to same address lands before the pending host write
    cpu_window = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h05; cpu_wdata = 8'h11;
    host_start(1'b1, 7'h05, 8'h99);
    tick();
    chk("t3_cpu_data", ram_data, 8'h11);
    chk("t3_cpu_en", ram_en, 1'b1);
    tick();
    chk("t3_mem_cpu", mem[7'h05], 8'h11);
    cpu_window = 1'b0; cpu_we = 1'b0;
    #1;
    chk("t3_host_data", ram_data, 8'h99);
    tick();
    chk("t3_ack", host_ack, 1'b1);
    chk("t3_mem_host", mem[7'h05], 8'h99);
    host_req = 1'b0;
    tick();

    // 4: timeout after 15 blocked PEND cycles
    cpu_write(7'h30, 8'h77);
    cpu_window = 1'b1; cpu_addr = 7'h01;
    host_start(1'b1, 7'h30, 8'hEE);
    tick();
    for (int i = 0; i < 15; i++) begin
      chk("t4_en", ram_en, 1'b0);
      chk("t4_noack", host_ack, 1'b0);
      tick();
    end
    chk("t4_ack", host_ack, 1'b1);
    chk("t4_err", host_err, 1'b1);
    host_req = 1'b0;
    repeat (5) begin
      chk("t4_en_after", ram_en, 1'b0);
      tick();
    end
    chk("t4_ack_low", host_ack, 1'b0);
    chk("t4_mem", mem[7'h30], 8'h77);
    cpu_window = 1'b0;

    // 5: reset mid-PEND with req held high
    cpu_window = 1'b1;
    host_start(1'b1, 7'h40, 8'hAB);
    tick();
    reset_n = 1'b0;
    #1;
    chk("t5_rst_ack", host_ack, 1'b0);
    tick();
    reset_n = 1'b1;
    cpu_window = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t5_no_en", ram_en, 1'b0);
      chk("t5_no_ack", host_ack, 1'b0);
      tick();
    end
    host_req = 1'b0;
    tick();
    host_start(1'b1, 7'h41, 8'hCD);
    tick();
    chk("t5_reaccept_en", ram_en, 1'b1);
    chk("t5_reaccept_addr", ram_addr, 7'h41);
    tick();
    chk("t5_ack", host_ack, 1'b1);
    chk("t5_mem", mem[7'h41], 8'hCD);

    // 6: req held high well past ack -> single transaction
    host_req = 1'b0;
    tick();
    acks = 0;
    host_start(1'b1, 7'h50, 8'h42);
    for (int i = 0; i < 14; i++) begin
      tick();
      if (host_ack) acks++;
    end
    chk("t6_ack_count", acks, 1);
    chk("t6_mem", mem[7'h50], 8'h42);
    host_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
